// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// the instruction-fill (I) and data load/store (D) requesters.
module mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_d;
    logic             owner_d;
    logic             grant_d;

    // D wins when it is alone, or on a tie when I was served last.
    assign grant_d = d_req & (~i_req | ~last_d);

    // The latched mem_addr/mem_we/mem_wdata registers double as the
    // memory-side outputs, so mid-access input changes cannot leak through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last_d    <= 1'b1;
            owner_d   <= 1'b0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_d   <= grant_d;
                        last_d    <= grant_d;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_we    <= grant_d & d_we;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        cnt       <= CNT_INIT;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        mem_en <= 1'b0;
                        state  <= RESP;
                        if (owner_d) begin
                            d_ready <= 1'b1;
                            if (!mem_we) d_rdata <= mem_rdata;
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LATENCY=4: latency, round-robin,
// stores, async reset abort and mid-access input changes.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_ready;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ready;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MEM_LATENCY(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: 0x40 holds 0xDEADBEEF, every other word is ~address.
    always_comb mem_rdata = (mem_addr == 32'h40) ? 32'hDEADBEEF : ~mem_addr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mem_en !== 1'b0 || busy !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got en=%b busy=%b ir=%b dr=%b exp all 0", mem_en, busy, i_ready, d_ready);
        end
        checks++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got i=%h d=%h exp 0", i_rdata, d_rdata);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem got we=%b a=%h wd=%h exp 0", mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_single_i();
        do_reset();
        i_addr = 32'h40; i_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            checks++;
            if (mem_en !== (c <= 4)) begin
                errors++; $display("FAIL single_en c=%0d got %b exp %b", c, mem_en, (c <= 4));
            end
            if (c <= 4) begin
                checks++;
                if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
                    errors++; $display("FAIL single_addr c=%0d got %h we=%b exp 00000040 we=0", c, mem_addr, mem_we);
                end
            end
            checks++;
            if (i_ready !== (c == 5) || d_ready !== 1'b0) begin
                errors++; $display("FAIL single_ready c=%0d got i=%b d=%b exp i=%b d=0", c, i_ready, d_ready, (c == 5));
            end
            if (c == 5) begin
                checks++;
                if (i_rdata !== 32'hDEADBEEF) begin
                    errors++; $display("FAIL single_rdata got %h exp deadbeef", i_rdata);
                end
                i_req = 1'b0;
            end
            if (c == 6) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++; $display("FAIL single_busy got %b exp 0", busy);
                end
            end
        end
    endtask

    task automatic test_tie();
        do_reset();
        i_addr = 32'h40; i_req = 1'b1;
        d_addr = 32'h100; d_we = 1'b0; d_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++;
            if (mem_en !== ((c >= 1 && c <= 4) || (c >= 7 && c <= 10))) begin
                errors++; $display("FAIL tie_en c=%0d got %b", c, mem_en);
            end
            if (c >= 7 && c <= 10) begin
                checks++;
                if (mem_addr !== 32'h100) begin
                    errors++; $display("FAIL tie_addr c=%0d got %h exp 00000100", c, mem_addr);
                end
            end
            checks++;
            if (i_ready !== (c == 5) || d_ready !== (c == 11)) begin
                errors++; $display("FAIL tie_ready c=%0d got i=%b d=%b exp i=%b d=%b", c, i_ready, d_ready, (c == 5), (c == 11));
            end
            if (c == 5) i_req = 1'b0;
            if (c == 11) begin
                checks++;
                if (d_rdata !== 32'hFFFFFEFF) begin
                    errors++; $display("FAIL tie_drdata got %h exp fffffeff", d_rdata);
                end
                d_req = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        bit done;
        do_reset();
        i_addr = 32'h40; d_addr = 32'h80; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        // I grants end cycles 0,12,24,..; D grants end cycles 6,18,..
        for (int c = 1; c <= 40; c++) begin
            step();
            checks++;
            if (i_ready !== ((c % 12) == 5) || d_ready !== ((c % 12) == 11)) begin
                errors++; $display("FAIL b2b_ready c=%0d got i=%b d=%b exp i=%b d=%b", c, i_ready, d_ready, (c % 12) == 5, (c % 12) == 11);
            end
            checks++;
            if (i_ready === 1'b1 && d_ready === 1'b1) begin
                errors++; $display("FAIL b2b_excl c=%0d got both ready exp exclusive", c);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step();
            if (busy === 1'b0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL b2b_drain got busy=%b exp 0 within 20 cycles", busy);
        end
    endtask

    task automatic test_store();
        bit seen;
        do_reset();
        d_addr = 32'h5555FFFF; d_we = 1'b0; d_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (d_ready === 1'b1) seen = 1'b1;
        end
        d_req = 1'b0;
        checks++;
        if (!seen || d_rdata !== 32'hAAAA0000) begin
            errors++; $display("FAIL store_preload got seen=%b d=%h exp 1 aaaa0000", seen, d_rdata);
        end
        step();
        d_addr = 32'h200; d_we = 1'b1; d_wdata = 32'h12345678; d_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            checks++;
            if (mem_en !== (c <= 4)) begin
                errors++; $display("FAIL store_en c=%0d got %b exp %b", c, mem_en, (c <= 4));
            end
            if (c <= 4) begin
                checks++;
                if (mem_we !== 1'b1 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h200) begin
                    errors++; $display("FAIL store_mem c=%0d got we=%b wd=%h a=%h exp 1 12345678 00000200", c, mem_we, mem_wdata, mem_addr);
                end
            end
            checks++;
            if (d_ready !== (c == 5) || i_ready !== 1'b0) begin
                errors++; $display("FAIL store_ready c=%0d got d=%b i=%b exp d=%b i=0", c, d_ready, i_ready, (c == 5));
            end
            if (c == 5) begin d_req = 1'b0; d_we = 1'b0; end
            if (c >= 5) begin
                checks++;
                if (d_rdata !== 32'hAAAA0000) begin
                    errors++; $display("FAIL store_drdata c=%0d got %h exp aaaa0000", c, d_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_addr = 32'h40; i_req = 1'b1;
        step();
        step();
        checks++;
        if (mem_en !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got en=%b exp 1", mem_en);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (mem_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got en=%b busy=%b exp 0 0", mem_en, busy);
        end
        i_req = 1'b0;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (i_ready !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
                errors++; $display("FAIL rstmid_quiet k=%0d got ir=%b busy=%b en=%b exp 0", k, i_ready, busy, mem_en);
            end
        end
        d_addr = 32'h20; d_we = 1'b0; d_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            checks++;
            if (mem_en !== (c <= 4) || d_ready !== (c == 5) || i_ready !== 1'b0) begin
                errors++; $display("FAIL rstmid_next c=%0d got en=%b dr=%b ir=%b exp en=%b dr=%b ir=0", c, mem_en, d_ready, i_ready, (c <= 4), (c == 5));
            end
        end
        d_req = 1'b0;
        checks++;
        if (d_rdata !== 32'hFFFFFFDF) begin
            errors++; $display("FAIL rstmid_rdata got %h exp ffffffdf", d_rdata);
        end
    endtask

    task automatic test_drop();
        do_reset();
        d_addr = 32'h80; d_we = 1'b0; d_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            checks++;
            if (mem_en !== (c <= 4) || busy !== (c <= 5)) begin
                errors++; $display("FAIL drop_en c=%0d got en=%b busy=%b exp en=%b busy=%b", c, mem_en, busy, (c <= 4), (c <= 5));
            end
            if (c <= 4) begin
                checks++;
                if (mem_addr !== 32'h80) begin
                    errors++; $display("FAIL drop_addr c=%0d got %h exp 00000080", c, mem_addr);
                end
            end
            checks++;
            if (d_ready !== (c == 5)) begin
                errors++; $display("FAIL drop_ready c=%0d got %b exp %b", c, d_ready, (c == 5));
            end
            if (c == 2) begin d_req = 1'b0; d_addr = 32'h300; end
        end
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_tie();
        test_back_to_back();
        test_store();
        test_reset_mid();
        test_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
